apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
APB completer that answers the master bridge's transfers on the same bus. It holds a DEPTH x 8-bit register memory and decodes the 8-bit PADDR against a base window. It inserts WAIT_CYCLES wait states via PREADY and flags out-of-window accesses with PSLVERR. Each peripheral slot (PSEL1/PSEL2) of the bridge gets one instance.

Parameters:
DEPTH, 64, number of 8-bit locations; 1..256, and BASE_ADDR+DEPTH must not exceed 256
BASE_ADDR, 8'h00, first PADDR value decoded by this instance
WAIT_CYCLES, 0, number of access-phase cycles with PREADY low before completion; 0..15

Ports:
PCLK  input  1  bus clock, rising edge
PRESETn  input  1  reset, asynchronous assert, active-low
PSEL  input  1  slave select from the bridge
PENABLE  input  1  access-phase strobe
PWRITE  input  1  1 = write, 0 = read
PADDR  input  8  byte address
PWDATA  input  8  write data
PRDATA  output  8  read data; valid only while PREADY=1 on a read
PREADY  output  1  transfer-complete strobe, registered
PSLVERR  output  1  error response; valid only while PREADY=1

Behaviour:
- Reset (PRESETn=0, asynchronous): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=8'h00, wait counter=0, all memory locations=8'h00.
- States and transitions:
  - IDLE to SETUP: on any edge with PSEL=1 and PENABLE=0.
  - SETUP: lasts one cycle. On that edge the block latches PADDR, PWRITE, PWDATA and the in-range flag, and loads counter=WAIT_CYCLES.
  - SETUP to ACCESS if WAIT_CYCLES=0, else SETUP to WAIT.
  - WAIT: counter decrements each edge. When counter reaches 1, go to ACCESS.
  - ACCESS: PREADY=1 for exactly one cycle, then IDLE. A new SETUP cycle seen on that edge goes directly to SETUP, so back-to-back transfers have no idle gap.
- Timing: setup phase at T0, first access cycle at T1. PREADY rises at T(1+WAIT_CYCLES). The transfer therefore completes in 2+WAIT_CYCLES cycles.
- PREADY, PSLVERR and PRDATA are registered. They are all 0 outside the ACCESS cycle.
- Decode: the access is in range if BASE_ADDR <= PADDR < BASE_ADDR+DEPTH. Index = PADDR-BASE_ADDR, using the low ceil(log2 DEPTH) bits.
- Write commit: mem[index] <= latched PWDATA on the edge ending the ACCESS cycle. This happens only if the access is in range and PSEL=1 and PENABLE=1 are still held.
- Read: PRDATA = mem[index], sampled when entering ACCESS.
- Write-then-read of the same address back-to-back returns the new data.
- Protocol abort: if PSEL=0 or PENABLE=0 during WAIT or ACCESS, go to IDLE. No write, PREADY=0, PSLVERR=0.
- PENABLE=1 seen in IDLE without a preceding setup cycle is ignored.
- The bus address and data are not re-sampled after SETUP. Changes during WAIT are ignored.
- Reset asserted mid-transfer: the transfer aborts immediately. Memory clears and any pending write is lost.

Optional Feature:
APB_SLV_ERR_EN
- Defined: an out-of-range access completes normally (same wait states) with PSLVERR=1 and PRDATA=8'h00. An out-of-range write does not modify memory.
- Not defined: PSLVERR is tied to 0. No range check is made; index = (PADDR-BASE_ADDR) mod DEPTH, so out-of-window addresses alias into memory.

Test Plan:
- WAIT_CYCLES=0: write 8'hA5 to 8'h10, then read 8'h10 -> PREADY high in T1 of each transfer; PRDATA=8'hA5; PSLVERR=0.
- WAIT_CYCLES=3: read 8'h05 after reset -> PREADY low for 3 access cycles, high on the 4th; PRDATA=8'h00.
- APB_SLV_ERR_EN defined, DEPTH=64, BASE_ADDR=0: write 8'h77 to 8'h50 -> PSLVERR=1 with PREADY. Then read 8'h10 -> PRDATA unchanged (8'h00 after reset).
- APB_SLV_ERR_EN undefined, same config: write 8'h77 to 8'h50, then read 8'h10 -> PRDATA=8'h77 (alias); PSLVERR=0.
- Back-to-back: write 8'h01 to 8'h00, write 8'h02 to 8'h01, read 8'h00 with no idle gaps -> each completes in 2+WAIT_CYCLES cycles; read returns 8'h01.
- WAIT_CYCLES=2, write 8'hFF to 8'h03: drop PSEL in the first wait cycle -> PREADY never asserts; a later read of 8'h03 returns 8'h00. Repeat with PRESETn pulsed low mid-wait -> outputs clear immediately; read returns 8'h00.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB completer: DEPTH x 8-bit register memory decoded at BASE_ADDR on an 8-bit PADDR.
// Latency: a transfer completes in 2+WAIT_CYCLES cycles (setup, WAIT_CYCLES waits, access).
// Backpressure: PREADY (registered) is held low for WAIT_CYCLES access cycles; a dropped PSEL/PENABLE aborts.
//
// Ports:
//   PCLK, PRESETn             bus clock (rising edge), asynchronous active-low reset
//   PSEL, PENABLE, PWRITE     APB control from the bridge
//   PADDR[7:0], PWDATA[7:0]   byte address and write data, sampled only in the setup cycle
//   PRDATA[7:0]               read data, non-zero only in the ACCESS cycle of an in-range read
//   PREADY, PSLVERR           registered completion strobe and error response
//
// Build option: define APB_SLV_ERR_EN to range-check accesses and answer out-of-window
// transfers with PSLVERR=1 (no memory update, PRDATA=0). Without it PSLVERR is always 0
// and out-of-window addresses alias into memory modulo DEPTH.

module apb_slave_mem #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 8'h00,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The bus setup phase has no state of its own: it is recognised combinationally in
  // IDLE (or on the final ACCESS edge) so that the registered PREADY can already be
  // high in the first access cycle when WAIT_CYCLES is 0.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            write_q, write_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            in_range_q, in_range_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [7:0]      prdata_q, prdata_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic [8:0]      off_ext;
  logic [AW-1:0]   bus_idx;
  logic            bus_in_range;

  logic            start;
  logic            held;
  logic            enter_access;
  logic            mem_we;
  logic [AW-1:0]   acc_idx;
  logic            acc_write;
  logic            acc_in_range;

  // Address decode of the live bus. The modulo keeps the index inside the array for any
  // DEPTH; for in-window addresses it is simply PADDR-BASE_ADDR.
  always_comb begin
    off_ext = {1'b0, PADDR - 8'(BASE_ADDR)};
    bus_idx = AW'(off_ext % 9'(DEPTH));
`ifdef APB_SLV_ERR_EN
    bus_in_range = ({1'b0, PADDR} >= 9'(BASE_ADDR)) &&
                   ({1'b0, PADDR} <  9'(BASE_ADDR + DEPTH));
`else
    bus_in_range = 1'b1;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    in_range_d   = in_range_q;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    prdata_d     = 8'h00;
    mem_we       = 1'b0;
    enter_access = 1'b0;
    acc_idx      = idx_q;
    acc_write    = write_q;
    acc_in_range = in_range_q;

    held  = PSEL && PENABLE;
    start = PSEL && !PENABLE && ((state_q == ST_IDLE) || (state_q == ST_ACCESS));

    unique case (state_q)
      ST_IDLE: begin
        // PENABLE without a preceding setup cycle is ignored here.
      end
      ST_WAIT: begin
        if (!held) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d      = ST_ACCESS;
          enter_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        // Commit only if the master is still in a valid access phase on the closing edge.
        state_d = ST_IDLE;
        mem_we  = held && write_q && in_range_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      idx_d      = bus_idx;
      write_d    = PWRITE;
      wdata_d    = PWDATA;
      in_range_d = bus_in_range;
      cnt_d      = 4'(WAIT_CYCLES);
      if (WAIT_CYCLES == 0) begin
        state_d      = ST_ACCESS;
        enter_access = 1'b1;
        acc_idx      = bus_idx;
        acc_write    = PWRITE;
        acc_in_range = bus_in_range;
      end else begin
        state_d = ST_WAIT;
      end
    end

    // A write commit always ends in IDLE, so it never coincides with a read entering
    // ACCESS; a following read therefore sees the updated array without a bypass.
    if (enter_access) begin
      pready_d = 1'b1;
`ifdef APB_SLV_ERR_EN
      pslverr_d = !acc_in_range;
`endif
      if (!acc_write && acc_in_range) begin
        prdata_d = mem_q[acc_idx];
      end
    end

    mem_d = mem_q;
    if (mem_we) begin
      mem_d[idx_q] = wdata_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      in_range_q <= in_range_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      mem_q      <= mem_d;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (no-wait 64-deep at base 0, 3-wait 48-deep at 8'h20).
// Table-driven directed vectors, hand-written abort/reset sequences, then random traffic
// checked against an array-based reference model of the memory map.

module tb_apb_slave_mem;

`ifdef APB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [1:0]      psel, penable, pwrite;
  logic [1:0][7:0] paddr, pwdata, prdata;
  logic [1:0]      pready, pslverr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [2][256];

  apb_slave_mem #(.DEPTH(64), .BASE_ADDR(8'h00), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_mem #(.DEPTH(48), .BASE_ADDR(8'h20), .WAIT_CYCLES(3)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int dep_of(input int d);
    return (d == 0) ? 64 : 48;
  endfunction
  function automatic int base_of(input int d);
    return (d == 0) ? 0 : 32;
  endfunction
  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'h00;
  endtask

  // Memory-map model: window check, modulo aliasing, read-before-write result.
  task automatic model_xfer(input int d, input bit wr, input logic [7:0] addr,
                            input logic [7:0] wd, output logic [7:0] rd, output bit er);
    int off, idx;
    bit inr;
    off = (int'(addr) - base_of(d) + 256) % 256;
    idx = off % dep_of(d);
    inr = (int'(addr) >= base_of(d)) && (int'(addr) < base_of(d) + dep_of(d));
    if (ERR_EN) begin
      er = !inr;
      rd = inr ? ref_mem[d][idx] : 8'h00;
      if (wr && inr) ref_mem[d][idx] = wd;
    end else begin
      er = 1'b0;
      rd = ref_mem[d][idx];
      if (wr) ref_mem[d][idx] = wd;
    end
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = 8'h00; pwdata[d] = 8'h00;
  endtask

  // Called and returns at #1 after a rising edge. Leaves the bus in its access phase so
  // a following call produces a back-to-back transfer. Address/data are scrambled after
  // setup to show they are not re-sampled.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                      output logic [7:0] rd, output bit er, output int lat, output bit zv);
    bit got;
    got = 1'b0; lat = 0; rd = 8'h00; er = 1'b0; zv = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1; paddr[d] = ~addr; pwdata[d] = ~wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready[d]) begin
        rd = prdata[d]; er = pslverr[d]; got = 1'b1;
        break;
      end
      if (prdata[d] != 8'h00 || pslverr[d]) zv = 1'b1;
      lat++;
      @(posedge clk); #1;
    end
    if (got) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_chk(input string tag, input int d, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd, input bit exp_er);
    logic [7:0] rd;
    bit er, zv;
    int lat;
    xfer(d, wr, addr, wd, rd, er, lat, zv);
    chk({tag, "_wait_cycles"}, lat, wait_of(d));
    chk({tag, "_pslverr"}, er, exp_er);
    chk({tag, "_zero_outside_access"}, zv, 1'b0);
    if (!wr) chk({tag, "_prdata"}, rd, exp_rd);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    bit         exp_er;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [7:0] mrd;
    bit mer;
    int cnt;

    rst_n = 1'b0;
    bus_idle(0); bus_idle(1);
    model_clear();

    tbl[0]  = '{1'b1, 8'h50, 8'h77, 8'h00, ERR_EN};
    tbl[1]  = '{1'b0, 8'h10, 8'h00, ERR_EN ? 8'h00 : 8'h77, 1'b0};
    tbl[2]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 8'h01, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h01, 8'h02, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 8'h01, 1'b0};
    tbl[7]  = '{1'b0, 8'h01, 8'h00, 8'h02, 1'b0};
    tbl[8]  = '{1'b0, 8'h50, 8'h00, ERR_EN ? 8'h00 : 8'hA5, ERR_EN};
    tbl[9]  = '{1'b1, 8'h3F, 8'h5A, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h3F, 8'h00, 8'h5A, 1'b0};
    tbl[11] = '{1'b0, 8'h40, 8'h00, ERR_EN ? 8'h00 : 8'h01, ERR_EN};
    tbl[12] = '{1'b1, 8'hFF, 8'h99, 8'h00, ERR_EN};
    tbl[13] = '{1'b0, 8'h3F, 8'h00, ERR_EN ? 8'h5A : 8'h99, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_pready_d%0d", d), pready[d], 1'b0);
      chk($sformatf("reset_pslverr_d%0d", d), pslverr[d], 1'b0);
      chk($sformatf("reset_prdata_d%0d", d), prdata[d], 8'h00);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // PENABLE without a setup cycle must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h10; pwdata[0] = 8'hEE;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (pready[0]) cnt++;
    end
    @(posedge clk); #1;
    bus_idle(0);
    chk("stray_penable_pready", cnt, 0);

    // Directed vectors, back to back with no idle cycles.
    for (int i = 0; i < 14; i++) begin
      model_xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, mrd, mer);
      run_chk($sformatf("vec%0d", i), 0, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_rd, tbl[i].exp_er);
    end
    bus_idle(0);

    // Three-wait instance: read after reset, window edges.
    run_chk("w3_read_05", 1, 1'b0, 8'h25, 8'h00, 8'h00, 1'b0);
    model_xfer(1, 1'b1, 8'h4F, 8'hC3, mrd, mer);
    run_chk("w3_write_top", 1, 1'b1, 8'h4F, 8'hC3, 8'h00, 1'b0);
    run_chk("w3_read_top", 1, 1'b0, 8'h4F, 8'h00, 8'hC3, 1'b0);
    model_xfer(1, 1'b0, 8'h50, 8'h00, mrd, mer);
    run_chk("w3_read_above", 1, 1'b0, 8'h50, 8'h00, mrd, mer);
    model_xfer(1, 1'b0, 8'h1F, 8'h00, mrd, mer);
    run_chk("w3_read_below", 1, 1'b0, 8'h1F, 8'h00, mrd, mer);
    bus_idle(1);

    // PSEL dropped in the first wait cycle: no completion, no write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h23; pwdata[1] = 8'hFF;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (pready[1]) cnt++;
      @(posedge clk); #1;
    end
    bus_idle(1);
    chk("abort_wait_pready", cnt, 0);
    model_xfer(1, 1'b0, 8'h23, 8'h00, mrd, mer);
    run_chk("abort_wait_readback", 1, 1'b0, 8'h23, 8'h00, mrd, 1'b0);
    bus_idle(1);

    // PSEL dropped during the access cycle of a write: no commit.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h3C; pwdata[0] = 8'hEE;
    @(posedge clk); #1;
    bus_idle(0);
    @(posedge clk); #1;
    model_xfer(0, 1'b0, 8'h3C, 8'h00, mrd, mer);
    run_chk("abort_access_readback", 0, 1'b0, 8'h3C, 8'h00, mrd, 1'b0);
    bus_idle(0);

    // Reset mid-transfer: instance 0 in its access cycle, instance 1 in a wait cycle.
    model_xfer(0, 1'b0, 8'h10, 8'h00, mrd, mer);
    psel = 2'b11; penable = 2'b00; pwrite = 2'b10;
    paddr[0] = 8'h10; paddr[1] = 8'h23; pwdata[1] = 8'hFF;
    @(posedge clk); #1;
    penable = 2'b11;
    @(negedge clk);
    chk("rst_pre_pready0", pready[0], 1'b1);
    chk("rst_pre_prdata0", prdata[0], mrd);
    chk("rst_pre_pready1", pready[1], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pready0", pready[0], 1'b0);
    chk("rst_async_prdata0", prdata[0], 8'h00);
    chk("rst_async_pready1", pready[1], 1'b0);
    bus_idle(0); bus_idle(1);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_chk("rst_readback1", 1, 1'b0, 8'h23, 8'h00, 8'h00, 1'b0);
    bus_idle(1);
    run_chk("rst_readback0", 0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
    bus_idle(0);

    // Random traffic against the model, with random idle gaps and stray strobes.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 250; n++) begin
        bit wr;
        logic [7:0] addr, wd;
        wr = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) addr = 8'($urandom_range(0, 255));
        else addr = 8'(base_of(d) + int'($urandom_range(0, dep_of(d) + 3)) - 2);
        wd = 8'($urandom_range(0, 255));
        model_xfer(d, wr, addr, wd, mrd, mer);
        run_chk($sformatf("rnd_d%0d_n%0d", d, n), d, wr, addr, wd, mrd, mer);
        if ($urandom_range(0, 3) == 0) begin
          psel[d] = 1'($urandom_range(0, 1));
          penable[d] = psel[d];
          repeat ($urandom_range(1, 2)) begin
            @(posedge clk); #1;
          end
        end
        bus_idle(d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
